change_dispenser: RTL

Returns change from the vending machine controller by driving the coin-return solenoids. It is the outbound counterpart of the nickel/dime/quarter coin inputs. On a start request it takes a change amount in cents and emits a sequence of timed coin-eject pulses, choosing the largest coin first. It falls back to smaller coins when a hopper is empty, and reports completion or an error.

---
 rtl/vmc_coin_pkg.sv | 32 +++
 rtl/coin_select.sv | 36 +++
 rtl/change_dispenser.sv | 112 +++++++++++
 3 files changed

// File: rtl/vmc_coin_pkg.sv
// rtl/vmc_coin_pkg.sv - coin values, FSM states and coin-select codes for the change dispenser
package vmc_coin_pkg;

  localparam int unsigned NICKEL_CENTS  = 5;
  localparam int unsigned DIME_CENTS    = 10;
  localparam int unsigned QUARTER_CENTS = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PULSE,
    ST_GAP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_NICKEL,
    COIN_DIME,
    COIN_QUARTER
  } coin_t;

  function automatic int unsigned coin_cents(coin_t c);
    case (c)
      COIN_NICKEL:  return NICKEL_CENTS;
      COIN_DIME:    return DIME_CENTS;
      COIN_QUARTER: return QUARTER_CENTS;
      default:      return 0;
    endcase
  endfunction

endpackage

// File: rtl/coin_select.sv
// rtl/coin_select.sv - largest-coin-first selection with fallback on empty hoppers
module coin_select
  import vmc_coin_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0] rem,
  input  logic             q_empty,
  input  logic             d_empty,
  input  logic             n_empty,
  output coin_t            coin,
  output logic             bad_amount,
  output logic             short_pay
);

  always_comb begin
    coin       = COIN_NONE;
    bad_amount = 1'b0;
    short_pay  = 1'b0;
    if ((rem % AMT_W'(NICKEL_CENTS)) != '0) begin
      bad_amount = 1'b1;
    end else if (rem == '0) begin
      coin = COIN_NONE;
    end else if (rem >= AMT_W'(QUARTER_CENTS) && !q_empty) begin
      coin = COIN_QUARTER;
    end else if (rem >= AMT_W'(DIME_CENTS) && !d_empty) begin
      coin = COIN_DIME;
    end else if (rem >= AMT_W'(NICKEL_CENTS) && !n_empty) begin
      coin = COIN_NICKEL;
    end else begin
      // money still owed but no usable hopper: report a short payout
      short_pay = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - timed coin-eject sequencer returning change to the customer
module change_dispenser
  import vmc_coin_pkg::*;
#(
  parameter int AMT_W        = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [AMT_W-1:0] i_change_cents,
  input  logic             i_q_empty,
  input  logic             i_d_empty,
  input  logic             i_n_empty,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_quarter_out,
  output logic             o_dime_out,
  output logic             o_nickel_out,
  output logic [AMT_W-1:0] o_remaining,
  output logic [3:0]       o_coin_count
);

  localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  state_t           state;
  coin_t            coin_q;
  logic [TMR_W-1:0] timer;
  coin_t            sel_coin;
  logic             sel_bad;
  logic             sel_short;

  coin_select #(.AMT_W(AMT_W)) u_coin_select (
    .rem        (o_remaining),
    .q_empty    (i_q_empty),
    .d_empty    (i_d_empty),
    .n_empty    (i_n_empty),
    .coin       (sel_coin),
    .bad_amount (sel_bad),
    .short_pay  (sel_short)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      coin_q        <= COIN_NONE;
      timer         <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_quarter_out <= 1'b0;
      o_dime_out    <= 1'b0;
      o_nickel_out  <= 1'b0;
      o_remaining   <= '0;
      o_coin_count  <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            o_remaining  <= i_change_cents;
            o_err        <= 1'b0;
            o_coin_count <= '0;
            o_busy       <= 1'b1;
            state        <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (sel_coin != COIN_NONE) begin
            coin_q        <= sel_coin;
            o_quarter_out <= (sel_coin == COIN_QUARTER);
            o_dime_out    <= (sel_coin == COIN_DIME);
            o_nickel_out  <= (sel_coin == COIN_NICKEL);
            timer         <= TMR_W'(PULSE_CYCLES - 1);
            state         <= ST_PULSE;
          end else begin
            o_err  <= sel_bad | sel_short;
            o_done <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_PULSE: begin
          if (timer == '0) begin
            o_quarter_out <= 1'b0;
            o_dime_out    <= 1'b0;
            o_nickel_out  <= 1'b0;
            // selection guarantees rem >= coin value, so no underflow here
            o_remaining   <= o_remaining - AMT_W'(coin_cents(coin_q));
            if (o_coin_count != 4'hF) o_coin_count <= o_coin_count + 4'd1;
            timer         <= TMR_W'(GAP_CYCLES - 1);
            state         <= ST_GAP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_GAP: begin
          if (timer == '0) state <= ST_CHECK;
          else timer <= timer - 1'b1;
        end
        ST_DONE: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
